// File: rtl/comp_seq_n.sv
// Sequential magnitude comparator: compares WIDTH-bit operands MSB-first,
// DIGIT bits per cycle, under a start/done handshake. Signed mode flips the
// sign bit on latch (offset-binary) so the scan itself is always unsigned.
// out_y[0] = a<b, out_y[1] = a==b, out_y[2] = a>b.
// Optional macro COMP_EARLY_EXIT_EN: finish on the first differing chunk
// instead of always scanning all WIDTH/DIGIT chunks (result is identical).
module comp_seq_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_busy,
  output logic             out_done,
  output logic [0:2]       out_y
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_cfg_err
    $error("comp_seq_n: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [0:2]       r_y;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [DIGIT-1:0] w_ca;
  logic [DIGIT-1:0] w_cb;
  logic             w_lt;
  logic             w_gt;
  logic             w_last;
  logic             w_stop;
  logic             w_fin_lt;
  logic             w_fin_gt;

`ifndef COMP_EARLY_EXIT_EN
  // First differing chunk seen during a full-length scan.
  logic             r_dec;
  logic             r_dec_gt;
`endif

  // Current chunk extraction: shift the chunk under the index up to the MSBs.
  always_comb begin
    w_a_sh = r_a << (r_idx * DIGIT);
    w_b_sh = r_b << (r_idx * DIGIT);
    w_ca   = w_a_sh[WIDTH-1 -: DIGIT];
    w_cb   = w_b_sh[WIDTH-1 -: DIGIT];
    w_lt   = (w_ca < w_cb);
    w_gt   = (w_ca > w_cb);
    w_last = (r_idx == IW'(N - 1));
  end

  // Decide when the scan ends and which result it produces.
  always_comb begin
`ifdef COMP_EARLY_EXIT_EN
    w_stop   = w_lt | w_gt | w_last;
    w_fin_lt = w_lt;
    w_fin_gt = w_gt;
`else
    w_stop   = w_last;
    w_fin_lt = r_dec ? ~r_dec_gt : w_lt;
    w_fin_gt = r_dec ?  r_dec_gt : w_gt;
`endif
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
`ifndef COMP_EARLY_EXIT_EN
      r_dec    <= 1'b0;
      r_dec_gt <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (in_start) begin
            r_a          <= in_a;
            r_b          <= in_b;
            // Offset-binary: flipping the sign bit makes signed order unsigned.
            r_a[WIDTH-1] <= in_a[WIDTH-1] ^ in_signed;
            r_b[WIDTH-1] <= in_b[WIDTH-1] ^ in_signed;
            r_idx        <= '0;
            r_busy       <= 1'b1;
            r_state      <= StScan;
`ifndef COMP_EARLY_EXIT_EN
            r_dec        <= 1'b0;
            r_dec_gt     <= 1'b0;
`endif
          end
        end
        StScan: begin
          if (w_stop) begin
            r_y[0]  <= w_fin_lt;
            r_y[1]  <= ~(w_fin_lt | w_fin_gt);
            r_y[2]  <= w_fin_gt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
`ifndef COMP_EARLY_EXIT_EN
            if (!r_dec && (w_lt || w_gt)) begin
              r_dec    <= 1'b1;
              r_dec_gt <= w_gt;
            end
`endif
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign out_busy = r_busy;
  assign out_done = r_done;
  assign out_y    = r_y;

endmodule

// File: tb/tb_comp_seq_n.sv
// Directed bench for comp_seq_n: one DIGIT=1 and one DIGIT=4 instance,
// a vector table of operations plus reset and mid-scan reset sequences.
module tb_comp_seq_n;

  localparam logic [0:2] YLt = 3'b100;
  localparam logic [0:2] YEq = 3'b010;
  localparam logic [0:2] YGt = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       s_i = 1'b0;

  logic       busy1, done1, busy2, done2;
  logic [0:2] y1, y2;
  logic       dsel = 1'b0;
  logic       busy_m, done_m;
  logic [0:2] y_m;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  comp_seq_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_start(start1), .in_a(a_i), .in_b(b_i), .in_signed(s_i),
    .out_busy(busy1), .out_done(done1), .out_y(y1)
  );

  comp_seq_n #(.WIDTH(8), .DIGIT(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_start(start2), .in_a(a_i), .in_b(b_i), .in_signed(s_i),
    .out_busy(busy2), .out_done(done2), .out_y(y2)
  );

  always_comb begin
    busy_m = dsel ? busy2 : busy1;
    done_m = dsel ? done2 : done1;
    y_m    = dsel ? y2 : y1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] a;
    logic [7:0] b;
    bit         sgn;
    logic [0:2] y;
    int         je;
    bit         inj;
  } vec_t;

  // Start one operation and check latency, busy length, result and pulse width.
  task automatic run_op(input vec_t v, input string nm);
    int ej;
    int j;
    int busy_cnt;
    int nchunks;
    logic [0:2] y_done;
    nchunks = v.sel ? 2 : 8;
`ifdef COMP_EARLY_EXIT_EN
    ej = v.je;
`else
    ej = nchunks;
`endif
    dsel = v.sel;
    a_i  = v.a;
    b_i  = v.b;
    s_i  = v.sgn;
    if (v.sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    if (v.inj) begin
      a_i = 8'hFF; b_i = 8'h00; s_i = 1'b0;
      start2 = 1'b1;
    end
    busy_cnt = busy_m ? 1 : 0;
    j = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) start2 = 1'b0;
      if (done_m) begin
        j = k;
        break;
      end
      if (busy_m) busy_cnt++;
    end
    y_done = y_m;
    chk({nm, " latency"}, j, ej);
    chk({nm, " y"}, {29'd0, y_done}, {29'd0, v.y});
    chk({nm, " busy_cycles"}, busy_cnt, ej);
    chk({nm, " busy_at_done"}, {31'd0, busy_m}, 32'd0);
    @(posedge clk); #1;
    chk({nm, " done_pulse_width"}, {31'd0, done_m}, 32'd0);
    chk({nm, " y_hold"}, {29'd0, y_m}, {29'd0, v.y});
  endtask

  vec_t vecs[13];
  bit   seen;

  initial begin
    vecs[0]  = '{0, 8'h80, 8'h7F, 0, YGt, 1, 0};
    vecs[1]  = '{0, 8'h80, 8'h7F, 1, YLt, 1, 0};
    vecs[2]  = '{0, 8'h5A, 8'h5A, 0, YEq, 8, 0};
    vecs[3]  = '{0, 8'h5A, 8'h5A, 1, YEq, 8, 0};
    vecs[4]  = '{0, 8'h01, 8'h02, 0, YLt, 7, 0};
    vecs[5]  = '{0, 8'hFF, 8'hFE, 1, YGt, 8, 0};
    vecs[6]  = '{0, 8'h00, 8'h80, 1, YGt, 1, 0};
    vecs[7]  = '{0, 8'h0F, 8'h10, 0, YLt, 4, 0};
    vecs[8]  = '{0, 8'hC0, 8'h40, 1, YLt, 1, 0};
    vecs[9]  = '{1, 8'h3C, 8'h3D, 0, YLt, 2, 1};
    vecs[10] = '{1, 8'h3C, 8'h3C, 1, YEq, 2, 0};
    vecs[11] = '{1, 8'h80, 8'h7F, 1, YLt, 1, 0};
    vecs[12] = '{1, 8'hA5, 8'h5A, 0, YGt, 1, 0};

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst y1", {29'd0, y1}, 32'd0);
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst done1", {31'd0, done1}, 32'd0);
    chk("rst y2", {29'd0, y2}, 32'd0);
    chk("rst busy2", {31'd0, busy2}, 32'd0);
    chk("rst done2", {31'd0, done2}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset at E0+3 aborts the scan without a done pulse and clears the result.
    dsel = 1'b0;
    a_i = 8'h01; b_i = 8'h02; s_i = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst y", {29'd0, y1}, 32'd0);
    chk("midrst busy", {31'd0, busy1}, 32'd0);
    chk("midrst done", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen = 1'b1;
    end
    chk("midrst no_done", {31'd0, seen}, 32'd0);
    run_op('{0, 8'h01, 8'h02, 0, YLt, 7, 0}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
